ss_sort_ctrl: RTL and testbench

SS_SORT_CTRL -- requirements
Module: ss_sort_ctrl

---
 rtl/ss_sort_ctrl.sv | 143 ++++++++++++++
 tb/tb_ss_sort_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ss_sort_ctrl.sv
// In-place ascending selection sort sequencer driving an external synchronous-read RAM.
// One pass per outer index: read a[i], scan the rest for the minimum, then swap if needed.
module ss_sort_ctrl #(
   parameter int N_ELEM = 8,
   parameter int DATA_W = 16,
   localparam int ADDR_W = ($clog2(N_ELEM) < 1) ? 1 : $clog2(N_ELEM)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data
);

   // state    | meaning
   // IDLE     | waiting for i_start
   // RD_I     | read a[i]
   // SCAN     | read a[j], compare data of a[j-1] against running minimum
   // CMP_LAST | compare data of a[N_ELEM-1], no read
   // SWAP1    | write min_val to a[i]
   // SWAP2    | write old a[i] to a[min_idx]
   // DONE     | o_done held until i_start drops
   typedef enum logic [2:0] {IDLE, RD_I, SCAN, CMP_LAST, SWAP1, SWAP2, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ELEM - 1);

   state_t            state;
   logic [ADDR_W-1:0] pass_idx;
   logic [ADDR_W-1:0] scan_idx;
   logic [ADDR_W-1:0] min_idx;
   logic [DATA_W-1:0] min_val;
   logic [DATA_W-1:0] ai_val;
   logic              first;

   logic              less;
   logic [ADDR_W-1:0] pass_nxt;
   logic [DATA_W-1:0] last_min;
   logic [ADDR_W-1:0] last_idx;
   logic              pass_end;

   assign less     = i_rd_data < min_val;
   assign pass_nxt = pass_idx + 1'b1;
   assign last_min = less ? i_rd_data : min_val;
   assign last_idx = less ? LAST : min_idx;
   // A pass ends straight out of CMP_LAST when nothing moves, otherwise after SWAP2.
   assign pass_end = ((state == CMP_LAST) && (last_idx == pass_idx)) || (state == SWAP2);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         pass_idx  <= '0;
         scan_idx  <= '0;
         min_idx   <= '0;
         min_val   <= '0;
         ai_val    <= '0;
         first     <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_rd_addr <= '0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else begin
         o_rd_addr <= '0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  pass_idx <= '0;
                  o_busy   <= 1'b1;
                  state    <= RD_I;
               end
            end
            RD_I: begin
               scan_idx  <= pass_nxt;
               o_rd_addr <= pass_nxt;
               first     <= 1'b1;
               state     <= SCAN;
            end
            SCAN: begin
               first <= 1'b0;
               if (first) begin
                  ai_val  <= i_rd_data;
                  min_val <= i_rd_data;
                  min_idx <= pass_idx;
               end else if (less) begin
                  min_val <= i_rd_data;
                  min_idx <= scan_idx - 1'b1;
               end
               if (scan_idx == LAST) begin
                  state <= CMP_LAST;
               end else begin
                  scan_idx  <= scan_idx + 1'b1;
                  o_rd_addr <= scan_idx + 1'b1;
               end
            end
            CMP_LAST: begin
               min_val <= last_min;
               min_idx <= last_idx;
               if (last_idx != pass_idx) begin
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= pass_idx;
                  o_wr_data <= last_min;
                  state     <= SWAP1;
               end
            end
            SWAP1: begin
               o_wr_en   <= 1'b1;
               o_wr_addr <= min_idx;
               o_wr_data <= ai_val;
               state     <= SWAP2;
            end
            SWAP2: ;
            DONE: begin
               if (!i_start) begin
                  o_done <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (pass_end) begin
            pass_idx <= pass_nxt;
            if (pass_nxt == LAST) begin
               o_busy <= 1'b0;
               o_done <= 1'b1;
               state  <= DONE;
            end else begin
               o_rd_addr <= pass_nxt;
               state     <= RD_I;
            end
         end
      end
   end

endmodule

// File: tb/tb_ss_sort_ctrl.sv
// Bench for ss_sort_ctrl: RAM model, queue-sort reference, handshake and reset-abort scenarios.
module tb_ss_sort_ctrl;
   localparam int N  = 8;
   localparam int W  = 16;
   localparam int AW = 3;

   typedef logic [W-1:0] arr_t [N];

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;

   arr_t mem;
   arr_t init_mem;
   logic load_req;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ss_sort_ctrl #(.N_ELEM(N), .DATA_W(W)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .o_busy    (busy),
      .o_done    (done),
      .o_rd_addr (rd_addr),
      .i_rd_data (rd_data),
      .o_wr_en   (wr_en),
      .o_wr_addr (wr_addr),
      .o_wr_data (wr_data)
   );

   // synchronous-read RAM; the bench preloads it through load_req
   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (load_req) mem <= init_mem;
      else if (wr_en) mem[wr_addr] <= wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_swaps(input arr_t a);
      int s = 0;
      for (int i = 0; i < N - 1; i++) begin
         int m = i;
         logic [W-1:0] t;
         for (int j = i + 1; j < N; j++)
            if (a[j] < a[m]) m = j;
         if (m != i) begin
            t = a[i]; a[i] = a[m]; a[m] = t;
            s++;
         end
      end
      return s;
   endfunction

   function automatic arr_t model_sorted(input arr_t a);
      logic [W-1:0] q[$];
      arr_t r;
      foreach (a[k]) q.push_back(a[k]);
      q.sort();
      foreach (r[k]) r[k] = q[k];
      return r;
   endfunction

   function automatic int pass_cycles();
      int c = 0;
      for (int i = 0; i < N - 1; i++) c += N - i + 1;
      return c;
   endfunction

   task automatic load(input arr_t a);
      @(negedge clk);
      init_mem = a;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_mem(input string tag, input arr_t exp);
      for (int k = 0; k < N; k++)
         chk($sformatf("%s_mem%0d", tag, k), 32'(mem[k]), 32'(exp[k]));
   endtask

   task automatic sort_check(input arr_t a, input string tag, input bit do_load);
      int   busy_c = 0, wr_c = 0, bad = 0, hold_bad = 0, idle_bad = 0;
      bit   got_done = 0;
      int   sw;
      arr_t exp_m;
      if (do_load) load(a);
      sw    = model_swaps(a);
      exp_m = model_sorted(a);
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (busy) busy_c++;
         if (wr_en) wr_c++;
         else if (wr_addr != 0 || wr_data != 0) bad++;
         if (!busy && rd_addr != 0) bad++;
         if (done) begin
            got_done = 1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(got_done), 1);
      chk({tag, "_busy_cycles"}, busy_c, pass_cycles() + 2 * sw);
      chk({tag, "_write_cycles"}, wr_c, 2 * sw);
      chk({tag, "_idle_outputs"}, bad, 0);
      repeat (5) begin
         @(negedge clk);
         if (!done || busy) hold_bad++;
      end
      chk({tag, "_done_hold"}, hold_bad, 0);
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_drop"}, 32'(done), 0);
      repeat (3) begin
         @(negedge clk);
         if (busy || done) idle_bad++;
      end
      chk({tag, "_no_retrigger"}, idle_bad, 0);
      check_mem(tag, exp_m);
   endtask

   initial begin
      arr_t a;
      arr_t partial;
      int   cnt;
      bit   seen;
      rst      = 1'b1;
      start    = 1'b0;
      load_req = 1'b0;
      init_mem = '{default: '0};
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);

      start = 1'b1;
      @(negedge clk);
      chk("rst_prio_busy", 32'(busy), 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);

      a = '{0, 1, 2, 3, 4, 5, 6, 7};
      sort_check(a, "sorted", 1);
      a = '{7, 6, 5, 4, 3, 2, 1, 0};
      sort_check(a, "reverse", 1);
      a = '{3, 1, 3, 1, 2, 2, 0, 0};
      sort_check(a, "dups", 1);

      // start dropped mid-sort: done must pulse for one cycle
      a = '{5, 9, 1, 1, 8, 0, 3, 2};
      load(a);
      @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk("pulse_done_seen", 32'(seen), 1);
      cnt = 1;
      repeat (4) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("pulse_done_width", cnt, 1);
      check_mem("pulse", model_sorted(a));

      // reset during pass i=2 SWAP1
      a = '{7, 6, 5, 4, 3, 2, 1, 0};
      load(a);
      @(negedge clk);
      start = 1'b1;
      seen  = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (wr_en && wr_addr == 2) begin
            seen = 1;
            break;
         end
      end
      chk("abort_swap1_seen", 32'(seen), 1);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_rd_addr", 32'(rd_addr), 0);
      chk("abort_wr_en", 32'(wr_en), 0);
      chk("abort_wr_addr", 32'(wr_addr), 0);
      chk("abort_wr_data", 32'(wr_data), 0);
      partial = '{0, 1, 2, 4, 3, 2, 6, 7};
      check_mem("abort_partial", partial);
      sort_check(partial, "resume", 0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < N; k++)
            a[k] = (r % 2 == 1) ? W'($urandom) : W'($urandom_range(0, 3));
         sort_check(a, $sformatf("rand%0d", r), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
